// File: rtl/mult16_seq_pkg.sv
// Shared constants for the sequential 16x16 multiplier: FSM states, widths and
// the per-pass operand-byte select and shift table.
package mult16_seq_pkg;

    localparam int NUM_PASSES = 4;
    localparam int OP_W       = 16;
    localparam int PROD_W     = 32;
    localparam int BYTE_W     = 8;
    localparam int SHIFT_W    = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Bit n set = pass n takes the high byte of that operand.
    localparam logic [NUM_PASSES-1:0] A_HI_SEL = 4'b1010;
    localparam logic [NUM_PASSES-1:0] B_HI_SEL = 4'b1100;

    localparam logic [NUM_PASSES-1:0][SHIFT_W-1:0] PASS_SHIFT = {5'd16, 5'd8, 5'd8, 5'd0};

endpackage

// File: rtl/multi_8.sv
// Combinational 8x8 unsigned array multiplier, full 16-bit product.
// Zero latency, no handshake: the product follows the operands.
module multi_8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    logic [15:0] prod;

    always_comb begin
        prod = '0;
        for (int i = 0; i < 8; i++) begin
            prod = prod + ({8'b0, a & {8{b[i]}}} << i);
        end
    end

    assign p = prod;

endmodule

// File: rtl/mult16_seq.sv
// Sequential 16x16 unsigned multiplier, four passes through one 8x8 array; result 4 (5 with PP_REG)
// cycles after accept. in_ready is low for the whole operation; p holds in DONE until out_ready.
module mult16_seq
    import mult16_seq_pkg::*;
#(
    parameter bit PP_REG       = 1'b0,
    parameter bit OUT_HOLD_CLR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] p,
    output logic              busy
);

    state_t              state;
    logic [1:0]          pass;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic [PROD_W-1:0]   acc;
    logic [OP_W-1:0]     pp_q;
    logic [SHIFT_W-1:0]  shift_q;

    logic [BYTE_W-1:0]   a_byte;
    logic [BYTE_W-1:0]   b_byte;
    logic [SHIFT_W-1:0]  shift;
    logic [OP_W-1:0]     pp;
    logic [PROD_W-1:0]   add_term;
    logic [PROD_W-1:0]   acc_sum;

    assign a_byte = A_HI_SEL[pass] ? a_q[15:8] : a_q[7:0];
    assign b_byte = B_HI_SEL[pass] ? b_q[15:8] : b_q[7:0];
    assign shift  = PASS_SHIFT[pass];

    multi_8 u_multi_8 (
        .a (a_byte),
        .b (b_byte),
        .p (pp)
    );

    // With PP_REG the adder sees last cycle's product, so it lags the byte muxes by one pass.
    assign add_term = PP_REG ? ({16'b0, pp_q} << shift_q) : ({16'b0, pp} << shift);
    assign acc_sum  = acc + add_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pass      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            pp_q      <= '0;
            shift_q   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        acc      <= '0;
                        pass     <= '0;
                        pp_q     <= '0;
                        shift_q  <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_MUL;
                    end
                end
                S_MUL: begin
                    pass <= pass + 2'd1;
                    acc  <= acc_sum;
                    if (PP_REG) begin
                        pp_q    <= pp;
                        shift_q <= shift;
                        if (pass == 2'd3) begin
                            state <= S_DRAIN;
                        end
                    end else if (pass == 2'd3) begin
                        p         <= acc_sum;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DRAIN: begin
                    acc       <= acc_sum;
                    p         <= acc_sum;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                        if (OUT_HOLD_CLR) begin
                            p <= '0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult16_seq.sv
// Directed bench for mult16_seq: products, fixed latency, backpressure, mid-op reset, back-to-back.
module tb_mult16_seq;

    localparam bit PP_REG = 1'b0;
    localparam int LAT    = PP_REG ? 5 : 4;
    localparam int II     = LAT + 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        busy;

    int n_assert;
    int n_fail;
    int cyc;

    mult16_seq #(
        .PP_REG       (PP_REG),
        .OUT_HOLD_CLR (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [31:0] exp, input string tag);
        int n;
        a         = ta;
        b         = tb_v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_in_ready_low"}, {31'b0, in_ready}, 32'd0);
        wait_out(n);
        chk({tag, "_latency"}, n, LAT);
        chk({tag, "_p"}, p, exp);
        @(posedge clk);
        #1;
        chk({tag, "_in_ready_back"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_out_valid_drop"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        int prev_acc;
        logic [15:0] ra;
        logic [15:0] rb;

        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_p", p, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(16'h1234, 16'h5678, 32'h06260060, "basic");
        run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "max");
        run_op(16'h00FF, 16'h0100, 32'h0000FF00, "bytesel");
        run_op(16'h0000, 16'hABCD, 32'h00000000, "zero");
        run_op(16'h8000, 16'h0002, 32'h00010000, "msb");

        // Backpressure: hold result while junk operands are offered.
        a         = 16'd3;
        b         = 16'd5;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(n);
        chk("bp_latency", n, LAT);
        for (int i = 0; i < 3; i++) begin
            a        = 16'h7000 + 16'(i);
            b        = 16'h0F00 + 16'(i);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_p_hold", p, 32'h0000000F);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
        chk("bp_p_clear", p, 32'd0);

        // Reset during pass 2.
        a         = 16'h1111;
        b         = 16'h2222;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_p", p, 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) pulses++;
        end
        chk("mrst_no_pulse", pulses, 0);
        run_op(16'd2, 16'd3, 32'd6, "after_rst");

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        prev_acc  = 0;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (in_ready !== 1'b1 && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            ra       = 16'($urandom);
            rb       = 16'($urandom);
            a        = ra;
            b        = rb;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            if (i == 7) in_valid = 1'b0;
            if (i > 0) chk("b2b_ii", cyc - prev_acc, II);
            prev_acc = cyc;
            wait_out(n);
            chk("b2b_latency", n, LAT);
            chk("b2b_p", p, {16'b0, ra} * {16'b0, rb});
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mult16_seq.md
Name: mult16_seq

Overview:
- Sequential 16x16 unsigned multiplier built on a single shared 8x8 array multiplier (`multi_8`), run for four passes per operation.
- An FSM selects operand bytes, shifts each 16-bit partial product and accumulates it into a 32-bit result.
- Operands enter and results leave through valid/ready handshakes.
- Sits between the operand source and the result consumer, wherever wider products are needed without a 16x16 array.

Parameters:
- PP_REG, 0: 1 = register the `multi_8` product before accumulation. Adds one cycle of latency and shortens the critical path.
- OUT_HOLD_CLR, 1: 1 = drive `p` to 0 whenever `out_valid`=0. 0 = `p` holds the last result.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair a/b is valid
- in_ready  out  1  block can accept operands
- a  in  16  multiplicand, unsigned
- b  in  16  multiplier, unsigned
- out_valid  out  1  product p is valid
- out_ready  in  1  consumer accepts p
- p  out  32  product a*b, unsigned
- busy  out  1  operation in progress (state MUL, DRAIN or DONE)

Behaviour:
- Clocking and reset: one clock (`clk`); reset (`rst`) is synchronous and active-high.
  - Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `p`=0, state=IDLE, pass=0, acc=0, pp_q=0.
- States: IDLE, MUL, DRAIN (exists only when PP_REG=1), DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready` at edge T: latch a_q<=a, b_q<=b; acc<=0; pass<=0; go to MUL.
  - `in_valid` without a transfer has no effect.
- MUL: the 2-bit pass counter selects the operand bytes and the shift.
  - pass 0: a_q[7:0] x b_q[7:0], shift 0.
  - pass 1: a_q[15:8] x b_q[7:0], shift 8.
  - pass 2: a_q[7:0] x b_q[15:8], shift 8.
  - pass 3: a_q[15:8] x b_q[15:8], shift 16.
  - PP_REG=0: acc <= acc + (pp << shift) in the same cycle. After pass 3, go to DONE.
  - PP_REG=1: pp_q and shift_q are registered; acc accumulates pp_q one cycle later. After pass 3, go to DRAIN.
  - DRAIN does the last accumulate, then goes to DONE.
- Arithmetic:
  - The shifted partial product is zero-extended to 32 bits.
  - The sum never exceeds 0xFFFE0001, so no overflow or carry-out logic is needed.
- Latency:
  - `out_valid` rises after edge T+4 when PP_REG=0, and after edge T+5 when PP_REG=1.
  - The cycle count is independent of the data; there is no early termination on zero operands.
- DONE:
  - `out_valid`=1 and `p`=acc.
  - `p` is stable while `out_valid`=1 & `out_ready`=0.
  - On `out_valid`&`out_ready`: go to IDLE next cycle.
  - `in_ready` stays 0 in DONE. No overlap: minimum initiation interval is 6 cycles (PP_REG=0) or 7 cycles (PP_REG=1).
- Inputs outside IDLE:
  - `a`/`b`/`in_valid` are ignored; a_q/b_q are never re-latched mid-operation.
  - `out_ready` is ignored outside DONE.
- Reset asserted in any state: next edge returns every output and register to its reset value. An in-flight operation is discarded and no `out_valid` pulse is produced.
- `multi_8` is purely combinational and must produce the full 16-bit unsigned product, including 0xFF x 0xFF = 0xFE01. It is verified standalone before integration.

Decomposition:
- `mult16_seq_pkg` holds:
  - state encodings (localparams S_IDLE, S_MUL, S_DRAIN, S_DONE);
  - NUM_PASSES=4, OP_W=16, PROD_W=32, BYTE_W=8;
  - the pass-to-byte-select/shift table as constants.
- Sub-module: one instance of the existing `multi_8`. Byte muxes, shifter, accumulator and FSM stay in `mult16_seq`; no further sub-modules.

Test Plan:
- Reset, then a=0x1234, b=0x5678, `out_ready`=1:
  - `p`=0x06260060;
  - `out_valid` asserted exactly 4 cycles after the accept edge (PP_REG=0), or 5 cycles (PP_REG=1).
- a=0xFFFF, b=0xFFFF -> `p`=0xFFFE0001. Then a=0x00FF, b=0x0100 -> `p`=0x0000FF00 (checks byte selection and shifts).
- a=0x0000, b=0xABCD -> `p`=0, with the same fixed latency. Also a=0x8000, b=0x0002 -> `p`=0x00010000.
- Backpressure, a=3, b=5:
  - hold `out_ready`=0 for 3 cycles; `p`=0x0000000F stays stable and `in_ready`=0 throughout;
  - change `a`/`b` during this time with `in_valid`=1 -> result unchanged;
  - `out_ready`=1 -> next cycle `in_ready`=1.
- Reset mid-operation: accept a=0x1111, b=0x2222, assert `rst` during pass 2:
  - next cycle all outputs are at reset values;
  - no `out_valid` pulse is produced;
  - a following a=2, b=3 yields `p`=6.
- Back-to-back, `in_valid` and `out_ready` held high with 8 random operand pairs: every `p` matches a*b, and the initiation interval is 6 cycles (PP_REG=0) or 7 cycles (PP_REG=1).
